// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset PC and PC step.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage : mips_pkg

// File: rtl/fetch_fifo.sv
// Instruction queue: power-of-two ring buffer with flush; head is read combinationally
// so a pushed entry is visible on the cycle after the push.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : fetch_fifo

// File: rtl/instr_fetch.sv
// Fetch stage: drives the external PC register, issues one instruction-memory read at a
// time, squashes reads overtaken by a redirect and queues fetched words for decode.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pcIn,
  output logic [31:0] nextPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instrOut,
  output logic [31:0] instrPC
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             push, pop, full, empty;
  logic [CNT_W-1:0] count, count_after_pop;
  logic [63:0]      head;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .flush_i (redirectValid),
    .push_i  (push),
    .data_i  ({pcIn, imemData}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pop               = ~empty & instrReady;
  assign count_after_pop   = count - CNT_W'(pop);
  assign instrValid        = ~empty;
  assign {instrPC, instrOut} = head;
  assign imemReq           = (state_q != ST_IDLE);
  assign imemAddr          = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A same-cycle pop frees a slot, so a full queue may still issue.
        if (!redirectValid && (!full || pop)) begin
          state_d = ST_REQ;
          addr_d  = pcIn;
        end
      end
      ST_REQ: begin
        if (redirectValid) begin
          state_d = imemAck ? ST_IDLE : ST_DROP;
        end else if (imemAck) begin
          push = 1'b1;
          if (count_after_pop < CNT_W'(DEPTH - 1)) addr_d = pcIn + PC_INCR;
          else                                     state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imemAck) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (RST)                               nextPC = RESET_PC;
    else if (redirectValid)                nextPC = redirectTarget;
    else if ((state_q == ST_REQ) && imemAck) nextPC = pcIn + PC_INCR;
    else                                   nextPC = pcIn;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch with an external PC register, a hashed memory and a
// queue-based reference model of the fetch stage.
module tb_instr_fetch;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pcIn;
  logic [31:0] nextPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = '0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = '0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instrOut;
  logic [31:0] instrPC;
  logic [31:0] pc_q;

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .pcIn           (pcIn),
    .nextPC         (nextPC),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemAck        (imemAck),
    .imemData       (imemData),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .instrValid     (instrValid),
    .instrReady     (instrReady),
    .instrOut       (instrOut),
    .instrPC        (instrPC)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) pc_q <= nextPC;
  assign pcIn = pc_q;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: busy = a read is outstanding, squash = that read was overtaken.
  logic [63:0] m_q [$];
  bit          m_busy   = 1'b0;
  bit          m_squash = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_pc     = '0;

  logic [31:0] pop_pcs [$];
  int          first_pop_step = -1;
  int          steps_since_rst = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, predict, clock, then compare registered outputs.
  task automatic step(input bit rst_v, input bit red_v, input logic [31:0] tgt_v,
                      input bit ack_v, input bit rdy_v);
    logic [31:0] exp_npc;
    bit          pop_v;
    RST            = rst_v;
    redirectValid  = red_v;
    redirectTarget = tgt_v;
    imemAck        = ack_v;
    instrReady     = rdy_v;
    imemData       = mem_word(imemAddr);
    #1;
    if (rst_v)                             exp_npc = RESET_PC_DEFAULT;
    else if (red_v)                        exp_npc = tgt_v;
    else if (m_busy && !m_squash && ack_v) exp_npc = m_pc + 32'd4;
    else                                   exp_npc = m_pc;
    check_eq("nextPC", 64'(nextPC), 64'(exp_npc));

    if (!rst_v && instrValid && rdy_v) begin
      $display("deliver pc=%h instr=%h", instrPC, instrOut);
      if (first_pop_step < 0) first_pop_step = steps_since_rst;
      pop_pcs.push_back(instrPC);
    end

    pop_v = !rst_v && (m_q.size() > 0) && rdy_v;
    if (rst_v) begin
      m_q.delete();
      m_busy   = 1'b0;
      m_squash = 1'b0;
      m_addr   = '0;
    end else begin
      if (pop_v) void'(m_q.pop_front());
      if (!m_busy) begin
        if (!red_v && m_q.size() < DEPTH) begin
          m_busy   = 1'b1;
          m_squash = 1'b0;
          m_addr   = m_pc;
        end
      end else if (m_squash) begin
        if (ack_v) m_busy = 1'b0;
      end else if (red_v) begin
        if (ack_v) m_busy = 1'b0;
        else       m_squash = 1'b1;
      end else if (ack_v) begin
        m_q.push_back({m_pc, imemData});
        if (m_q.size() < DEPTH) m_addr = m_pc + 32'd4;
        else                    m_busy = 1'b0;
      end
      if (red_v) m_q.delete();
    end
    m_pc = exp_npc;
    steps_since_rst = rst_v ? 0 : steps_since_rst + 1;

    @(posedge CLK);
    @(negedge CLK);
    check_eq("pcIn", 64'(pcIn), 64'(m_pc));
    check_eq("imemReq", 64'(imemReq), 64'(m_busy));
    check_eq("imemAddr", 64'(imemAddr), 64'(m_addr));
    check_eq("instrValid", 64'(instrValid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check_eq("instrPC", 64'(instrPC), 64'(m_q[0][63:32]));
      check_eq("instrOut", 64'(instrOut), 64'(m_q[0][31:0]));
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    pop_pcs.delete();
    first_pop_step = -1;
  endtask

  task automatic run_to_addr8();
    for (int i = 0; i < 20; i++) begin
      if (imemReq && imemAddr == 32'h8) break;
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    end
    check_eq("reach8", 64'(imemReq && imemAddr == 32'h8), 64'd1);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] tgt;
    int          rdy_pct;

    // Streaming start-up with memory always ready.
    do_reset();
    check_eq("rst_npc", 64'(nextPC), 64'(RESET_PC_DEFAULT));
    check_eq("rst_req", 64'(imemReq), 64'd0);
    check_eq("rst_valid", 64'(instrValid), 64'd0);
    check_eq("rst_addr", 64'(imemAddr), 64'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_eq("a_first", 64'(first_pop_step), 64'd2);
    check_eq("a_npops", 64'(pop_pcs.size()), 64'd4);
    check_eq("a_pc0", 64'(pop_pcs[0]), 64'h0);
    check_eq("a_pc1", 64'(pop_pcs[1]), 64'h4);
    check_eq("a_pc2", 64'(pop_pcs[2]), 64'h8);

    // Fill with decode stalled, then drain.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("fill_req", 64'(imemReq), 64'd0);
    check_eq("fill_pc", 64'(pcIn), 64'h10);
    pop_pcs.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("fill_n", 64'(pop_pcs.size()), 64'd4);
    check_eq("fill_pc3", 64'(pop_pcs[3]), 64'hC);

    // Ack held off three cycles at address 8.
    do_reset();
    run_to_addr8();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check_eq("dly_addr", 64'(imemAddr), 64'h8);
      check_eq("dly_req", 64'(imemReq), 64'd1);
      check_eq("dly_npc", 64'(nextPC), 64'h8);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_eq("dly_pc12", 64'(pcIn), 64'hC);

    // Redirect overtakes an unacknowledged read.
    do_reset();
    run_to_addr8();
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    check_eq("drop_req", 64'(imemReq), 64'd1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_eq("drop_valid", 64'(instrValid), 64'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("drop_addr", 64'(imemAddr), 64'h100);

    // Redirect coincident with ack and pop while two entries are queued.
    do_reset();
    for (int i = 0; i < 10 && m_q.size() < 2; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("two_q", 64'(m_q.size()), 64'd2);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    check_eq("flush_valid", 64'(instrValid), 64'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("flush_addr", 64'(imemAddr), 64'h200);

    // PC wrap past the top of the address space.
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    imemAck = 1'b1;
    #1;
    check_eq("wrap", 64'(nextPC), 64'h0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Randomized traffic under varying decode back-pressure.
    for (int ph = 0; ph < 3; ph++) begin
      rdy_pct = (ph == 0) ? 90 : ((ph == 1) ? 50 : 15);
      for (int i = 0; i < 1000; i++) begin
        rnd = $urandom();
        tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {rnd[31:2], 2'b00};
        step($urandom_range(0, 599) == 0,
             $urandom_range(0, 11) == 0,
             tgt,
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 99) < rdy_pct);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instr_fetch
